// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: hex glyph table, blank pattern and nibble type.
// Patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef logic [3:0] hex_nibble_t;

    localparam logic [6:0] BLANK_SEG = 7'b1111111;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  hex_nibble_t nibble_i,
    output logic [6:0]  seg_o
);

    // Table lookup of the glyph for the selected nibble
    always_comb begin
        seg_o = SEG_TABLE[nibble_i];
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner with double-buffered display data,
// per-slot dead time, digit enables and leading-zero blanking.
module seven_segment_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int CLK_DIV     = 100000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_suppress,
    input  logic                    load,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         sh_digits_q, sh_digits_d, act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0] sh_en_q, sh_en_d, act_en_q, act_en_d;
    logic                  sh_lz_q, sh_lz_d, act_lz_q, act_lz_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  frame_done_q, frame_done_d;

    logic                  presc_tc_s, wrap_s, dead_s;
    logic [NUM_DIGITS-1:0] lz_mask_s;
    hex_nibble_t           sel_nibble_s;
    logic                  sel_en_s, sel_dp_s, sel_lz_s;
    logic [6:0]            dec_seg_s;

    // Slot timing and selection of the digit currently being scanned
    always_comb begin
        presc_tc_s   = (presc_q == PRESC_LAST);
        wrap_s       = presc_tc_s && (idx_q == IDX_LAST);
        dead_s       = (int'(presc_q) < DEAD_CYCLES);
        sel_nibble_s = act_digits_q[{idx_q, 2'b00} +: 4];
        sel_en_s     = act_en_q[idx_q];
        sel_dp_s     = act_dp_q[idx_q];
        sel_lz_s     = lz_mask_s[idx_q];
    end

    // Leading-zero mask: walk down from the top, disabled digits do not break the run of zeros
    always_comb begin
        logic zero_above;
        logic nib_zero;
        zero_above = 1'b1;
        nib_zero   = 1'b0;
        lz_mask_s  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib_zero     = (act_digits_q[4*i +: 4] == 4'h0);
            lz_mask_s[i] = act_lz_q && nib_zero && zero_above && (i > 0);
            zero_above   = zero_above && !(act_en_q[i] && !nib_zero);
        end
    end

    seg_hex_decoder u_dec (
        .nibble_i (sel_nibble_s),
        .seg_o    (dec_seg_s)
    );

    // Prescaler, scan index and shadow/active buffer next state
    always_comb begin
        presc_d      = presc_q + PW'(1);
        idx_d        = idx_q;
        frame_done_d = wrap_s;
        act_digits_d = act_digits_q;
        act_dp_d     = act_dp_q;
        act_en_d     = act_en_q;
        act_lz_d     = act_lz_q;
        if (presc_tc_s) begin
            presc_d = '0;
            if (wrap_s) begin
                idx_d        = '0;
                act_digits_d = sh_digits_q;
                act_dp_d     = sh_dp_q;
                act_en_d     = sh_en_q;
                act_lz_d     = sh_lz_q;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
        // A load on the wrap cycle lands in the shadow only, so it waits one frame
        if (load) begin
            sh_digits_d = digits;
            sh_dp_d     = dp_in;
            sh_en_d     = digit_en;
            sh_lz_d     = lz_suppress;
        end else begin
            sh_digits_d = sh_digits_q;
            sh_dp_d     = sh_dp_q;
            sh_en_d     = sh_en_q;
            sh_lz_d     = sh_lz_q;
        end
    end

    // Drive pattern for the current slot; a suppressed digit keeps its anode only to show dp
    always_comb begin
        seg_d   = BLANK_SEG;
        dp_d    = 1'b1;
        anode_d = '1;
        if (!dead_s && sel_en_s) begin
            dp_d = ~sel_dp_s;
            if (!sel_lz_s) begin
                seg_d   = dec_seg_s;
                anode_d = ~(NUM_DIGITS'(1) << idx_q);
            end else if (sel_dp_s) begin
                anode_d = ~(NUM_DIGITS'(1) << idx_q);
            end else begin
                anode_d = '1;
            end
        end else begin
            seg_d = BLANK_SEG;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            sh_digits_q  <= '0;
            sh_dp_q      <= '0;
            sh_en_q      <= '0;
            sh_lz_q      <= 1'b0;
            act_digits_q <= '0;
            act_dp_q     <= '0;
            act_en_q     <= '0;
            act_lz_q     <= 1'b0;
            seg_q        <= BLANK_SEG;
            dp_q         <= 1'b1;
            anode_q      <= '1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            sh_digits_q  <= sh_digits_d;
            sh_dp_q      <= sh_dp_d;
            sh_en_q      <= sh_en_d;
            sh_lz_q      <= sh_lz_d;
            act_digits_q <= act_digits_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
            act_lz_q     <= act_lz_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            anode_q      <= anode_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign segments   = seg_q;
    assign dp         = dp_q;
    assign anode      = anode_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (4 digits, 4 cycles per slot, 1 dead cycle).
module tb_seven_segment_scanner;

    localparam int ND = 4;
    localparam int CD = 4;
    localparam int DC = 1;

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        lz;
    } payload_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_suppress;
    logic        load;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anode;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    int       m_presc;
    int       m_idx;
    payload_t m_sh;
    payload_t m_act;

    seven_segment_scanner #(
        .NUM_DIGITS  (ND),
        .CLK_DIV     (CD),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits      (digits),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .lz_suppress (lz_suppress),
        .load        (load),
        .segments    (segments),
        .dp          (dp),
        .anode       (anode),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Expected registered outputs for the edge that follows the current model state
    function automatic exp_t model_out();
        exp_t        e;
        logic [15:0] dig;
        logic [3:0]  en;
        logic [3:0]  dpv;
        logic [3:0]  nib;
        logic        supp;
        e.an  = 4'b1111;
        e.seg = 7'b1111111;
        e.dp  = 1'b1;
        e.fd  = (m_presc == CD - 1) && (m_idx == ND - 1);
        if (m_presc >= DC) begin
            dig  = m_act.dig;
            en   = m_act.en;
            dpv  = m_act.dp;
            nib  = dig[m_idx*4 +: 4];
            supp = m_act.lz && (m_idx > 0) && (nib == 4'h0);
            for (int j = m_idx + 1; j < ND; j++) begin
                if (en[j] && (dig[j*4 +: 4] != 4'h0)) supp = 1'b0;
            end
            if (en[m_idx]) begin
                e.dp = ~dpv[m_idx];
                if (!supp) begin
                    e.seg        = hex_seg(nib);
                    e.an[m_idx]  = 1'b0;
                end else if (dpv[m_idx]) begin
                    e.an[m_idx]  = 1'b0;
                end
            end
        end
        return e;
    endfunction

    task automatic model_adv(input logic ld, input payload_t p);
        if (m_presc == CD - 1) begin
            m_presc = 0;
            if (m_idx == ND - 1) begin
                m_idx = 0;
                m_act = m_sh;
            end else begin
                m_idx++;
            end
        end else begin
            m_presc++;
        end
        if (ld) m_sh = p;
    endtask

    task automatic model_reset();
        m_presc = 0;
        m_idx   = 0;
        m_sh    = '0;
        m_act   = '0;
    endtask

    // One clock: drive at negedge, push expectation, compare after the edge, return at negedge
    task automatic step(input logic ld, input payload_t p);
        exp_t e;
        load = ld;
        if (ld) begin
            digits      = p.dig;
            dp_in       = p.dp;
            digit_en    = p.en;
            lz_suppress = p.lz;
        end else begin
            digits      = 16'($urandom);
            dp_in       = 4'($urandom);
            digit_en    = 4'($urandom);
            lz_suppress = 1'($urandom);
        end
        sb.push_back(model_out());
        model_adv(ld, p);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_anode", 32'(anode), 32'(e.an));
        chk("sb_segments", 32'(segments), 32'(e.seg));
        chk("sb_dp", 32'(dp), 32'(e.dp));
        chk("sb_frame_done", 32'(frame_done), 32'(e.fd));
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input logic first_ld, input payload_t first_p);
        int n;
        payload_t none_p;
        none_p = '0;
        step(first_ld, first_p);
        n = 1;
        while (frame_done !== 1'b1 && n < 40) begin
            step(1'b0, none_p);
            n++;
        end
        chk(tag, 32'(n), 32'd16);
    endtask

    // Full frame with directed per-slot expectations; slot s packed at [7s+6:7s] / [4s+3:4s] / [s]
    task automatic run_frame(input string name, input logic [27:0] segs, input logic [15:0] ans,
                             input logic [3:0] dps, input int ld_a, input payload_t pa,
                             input int ld_b, input payload_t pb);
        int slot;
        payload_t none_p;
        none_p = '0;
        for (int k = 0; k < 16; k++) begin
            if (k == ld_a) step(1'b1, pa);
            else if (k == ld_b) step(1'b1, pb);
            else step(1'b0, none_p);
            slot = k / 4;
            if (k % 4 == 0) begin
                chk({name, "_dead_anode"}, 32'(anode), 32'hF);
                chk({name, "_dead_seg"}, 32'(segments), 32'h7F);
                chk({name, "_dead_dp"}, 32'(dp), 32'd1);
            end else begin
                chk({name, "_anode"}, 32'(anode), 32'(ans[slot*4 +: 4]));
                chk({name, "_seg"}, 32'(segments), 32'(segs[slot*7 +: 7]));
                chk({name, "_dp"}, 32'(dp), 32'(dps[slot]));
            end
        end
        chk({name, "_frame_done"}, 32'(frame_done), 32'd1);
    endtask

    initial begin
        payload_t none_p, p_12af, p_0070, p_x, p_y;
        none_p = '0;
        p_12af = '{dig: 16'h12AF, dp: 4'b0000, en: 4'b1111, lz: 1'b0};
        p_0070 = '{dig: 16'h0070, dp: 4'b0100, en: 4'b1111, lz: 1'b1};
        p_x    = '{dig: 16'h3456, dp: 4'b0001, en: 4'b1111, lz: 1'b0};
        p_y    = '{dig: 16'h89CD, dp: 4'b0000, en: 4'b1010, lz: 1'b0};

        reset       = 1'b1;
        load        = 1'b0;
        digits      = 16'h0;
        dp_in       = 4'h0;
        digit_en    = 4'h0;
        lz_suppress = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_anode", 32'(anode), 32'hF);
        chk("reset_segments", 32'(segments), 32'h7F);
        chk("reset_dp", 32'(dp), 32'd1);
        chk("reset_frame_done", 32'(frame_done), 32'd0);

        // Release with a load in the same cycle; active data is still zero for this frame
        @(negedge clk);
        reset = 1'b0;
        wait_frame("first_frame_done", 1'b1, p_12af);

        run_frame("hex_12af", {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110},
                  {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1111, -1, none_p, -1, none_p);
        run_frame("hold_12af", {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110},
                  {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1111, 0, p_0070, -1, none_p);
        // Mid-frame load of X, then a load of Y on the wrap cycle
        run_frame("lz_0070", {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000},
                  {4'b1111, 4'b1011, 4'b1101, 4'b1110}, 4'b1011, 6, p_x, 15, p_y);
        run_frame("mid_load_x", {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010},
                  {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1110, -1, none_p, -1, none_p);
        run_frame("wrap_load_y_en1010", {7'b0000000, 7'b1111111, 7'b1000110, 7'b1111111},
                  {4'b0111, 4'b1111, 4'b1101, 4'b1111}, 4'b1111, 3, p_x, -1, none_p);

        // Into slot 2 of the next X frame, then reset asynchronously
        for (int k = 0; k < 10; k++) step(1'b0, none_p);
        chk("pre_reset_slot2_anode", 32'(anode), 32'hB);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_anode", 32'(anode), 32'hF);
        chk("async_reset_segments", 32'(segments), 32'h7F);
        chk("async_reset_dp", 32'(dp), 32'd1);
        chk("async_reset_frame_done", 32'(frame_done), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_frame("restart_frame_done", 1'b0, none_p);
        run_frame("cleared_after_reset", {4{7'b1111111}}, 16'hFFFF, 4'b1111,
                  -1, none_p, -1, none_p);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
